// File: rtl/botao_debounce_if.sv
// Button conditioning bundle: the raw pin going in, and the clean level
// plus its edge strobes coming out toward botao and other consumers.
interface botao_debounce_if;
  logic btn_raw;
  logic press;
  logic press_rise;
  logic press_fall;

  modport master (
    output btn_raw,
    input  press,
    input  press_rise,
    input  press_fall
  );

  modport slave (
    input  btn_raw,
    output press,
    output press_rise,
    output press_fall
  );
endinterface

// File: rtl/botao_debounce.sv
// Push-button debouncer: two-flop synchroniser followed by a counter-based
// qualification FSM. press only changes after DEBOUNCE_CYCLES consecutive
// synchronised samples at the new level; rise/fall strobes mark the change.
module botao_debounce #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int ACTIVE_LOW      = 1
) (
  input logic             clk,
  input logic             rst_n,
  botao_debounce_if.slave btn
);

  localparam int               CNT_W   = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic             POL     = (ACTIVE_LOW != 0);

  typedef enum logic [1:0] {
    IDLE_LOW,
    WAIT_HIGH,
    IDLE_HIGH,
    WAIT_LOW
  } state_t;

  logic             sync1;
  logic             s;
  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic             press_next;
  logic             rise_next;
  logic             fall_next;

  // Bring the pin into the clk domain, normalised so 1 always means pressed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      s     <= 1'b0;
    end else begin
      sync1 <= btn.btn_raw ^ POL;
      s     <= sync1;
    end
  end

  // Qualification decisions: count agreeing samples, restart on any bounce.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    rise_next  = 1'b0;
    fall_next  = 1'b0;
    case (state)
      IDLE_LOW: begin
        cnt_next = '0;
        if (s) begin
          state_next = WAIT_HIGH;
          cnt_next   = CNT_ONE;
        end
      end
      WAIT_HIGH: begin
        if (!s) begin
          state_next = IDLE_LOW;
          cnt_next   = '0;
        end else if (cnt == CNT_MAX) begin
          state_next = IDLE_HIGH;
          cnt_next   = '0;
          rise_next  = 1'b1;
        end else begin
          cnt_next = cnt + CNT_ONE;
        end
      end
      IDLE_HIGH: begin
        cnt_next = '0;
        if (!s) begin
          state_next = WAIT_LOW;
          cnt_next   = CNT_ONE;
        end
      end
      WAIT_LOW: begin
        if (s) begin
          state_next = IDLE_HIGH;
          cnt_next   = '0;
        end else if (cnt == CNT_MAX) begin
          state_next = IDLE_LOW;
          cnt_next   = '0;
          fall_next  = 1'b1;
        end else begin
          cnt_next = cnt + CNT_ONE;
        end
      end
      default: begin
        state_next = IDLE_LOW;
        cnt_next   = '0;
      end
    endcase
  end

  assign press_next = (state_next == IDLE_HIGH) || (state_next == WAIT_LOW);

  // Register state, counter and all outputs so nothing is combinational from the pin.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE_LOW;
      cnt            <= '0;
      btn.press      <= 1'b0;
      btn.press_rise <= 1'b0;
      btn.press_fall <= 1'b0;
    end else begin
      state          <= state_next;
      cnt            <= cnt_next;
      btn.press      <= press_next;
      btn.press_rise <= rise_next;
      btn.press_fall <= fall_next;
    end
  end

endmodule

// File: tb/tb_botao_debounce.sv
// Bench for botao_debounce: two instances (active-low pin with 4-cycle
// qualification, active-high pin with 2-cycle qualification), a run-length
// reference model checked every cycle, and directed literal latency checks.
module tb_botao_debounce;

  localparam int D_A = 4;
  localparam int D_B = 2;

  logic clk = 1'b0;
  logic rst_n;
  int   n_vec = 0;
  int   n_err = 0;

  botao_debounce_if if_a ();
  botao_debounce_if if_b ();

  botao_debounce #(.DEBOUNCE_CYCLES(D_A), .ACTIVE_LOW(1)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (if_a)
  );

  botao_debounce #(.DEBOUNCE_CYCLES(D_B), .ACTIVE_LOW(0)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (if_b)
  );

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  // Reference model state per instance: pin samples in flight, the run of
  // consecutive samples disagreeing with the current level, and the outputs.
  logic m_sync1 [2] = '{1'b0, 1'b0};
  logic m_s     [2] = '{1'b0, 1'b0};
  logic m_press [2] = '{1'b0, 1'b0};
  logic m_rise  [2] = '{1'b0, 1'b0};
  logic m_fall  [2] = '{1'b0, 1'b0};
  int   m_run   [2] = '{0, 0};

  task automatic model_step(input int i, input logic pressed, input int d);
    logic seen;
    seen      = m_s[i];
    m_rise[i] = 1'b0;
    m_fall[i] = 1'b0;
    if (seen != m_press[i]) begin
      m_run[i] = m_run[i] + 1;
      if (m_run[i] == d) begin
        m_press[i] = seen;
        m_rise[i]  = seen;
        m_fall[i]  = ~seen;
        m_run[i]   = 0;
      end
    end else begin
      m_run[i] = 0;
    end
    m_s[i]     = m_sync1[i];
    m_sync1[i] = pressed;
  endtask

  // Advance the reference model each clock; reset discards everything at once.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        m_sync1[i] = 1'b0;
        m_s[i]     = 1'b0;
        m_press[i] = 1'b0;
        m_rise[i]  = 1'b0;
        m_fall[i]  = 1'b0;
        m_run[i]   = 0;
      end
    end else begin
      model_step(0, ~if_a.btn_raw, D_A);
      model_step(1, if_b.btn_raw, D_B);
    end
  end

  task automatic check_output(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_value(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Compare both instances against the model shortly after every rising edge.
  always @(posedge clk) begin
    #1;
    check_output("model_press_a", if_a.press,      m_press[0]);
    check_output("model_rise_a",  if_a.press_rise, m_rise[0]);
    check_output("model_fall_a",  if_a.press_fall, m_fall[0]);
    check_output("model_press_b", if_b.press,      m_press[1]);
    check_output("model_rise_b",  if_b.press_rise, m_rise[1]);
    check_output("model_fall_b",  if_b.press_fall, m_fall[1]);
  end

  // Stand-in for the downstream botao toggle: flips on each rise strobe.
  logic detect   = 1'b0;
  int   rise_b_n = 0;
  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      detect   <= 1'b0;
      rise_b_n <= 0;
    end else if (if_b.press_rise) begin
      detect   <= ~detect;
      rise_b_n <= rise_b_n + 1;
    end
  end

  function automatic logic get_press(input int sel);
    return (sel == 0) ? if_a.press : if_b.press;
  endfunction

  function automatic logic get_rise(input int sel);
    return (sel == 0) ? if_a.press_rise : if_b.press_rise;
  endfunction

  function automatic logic get_fall(input int sel);
    return (sel == 0) ? if_a.press_fall : if_b.press_fall;
  endfunction

  task automatic apply_stimulus(input int sel, input logic pressed);
    if (sel == 0) if_a.btn_raw = ~pressed;
    else          if_b.btn_raw = pressed;
  endtask

  // Edge index (E0 = first edge after the pin change) at which press reaches target.
  task automatic measure_edge(input int sel, input logic target, output int k_out);
    k_out = -1;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      if (get_press(sel) == target) begin
        k_out = k;
        break;
      end
    end
  endtask

  task automatic hold_check(input int sel, input logic exp_press, input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      check_output("hold_press", get_press(sel), exp_press);
      check_output("hold_rise",  get_rise(sel),  1'b0);
      check_output("hold_fall",  get_fall(sel),  1'b0);
    end
  endtask

  task automatic qualify(input int sel, input logic target, input int exp_edge, input string name);
    int k;
    measure_edge(sel, target, k);
    check_value(name, k, exp_edge);
    check_output({name, "_strobe"}, target ? get_rise(sel) : get_fall(sel), 1'b1);
    check_output({name, "_other"},  target ? get_fall(sel) : get_rise(sel), 1'b0);
    @(posedge clk);
    #1;
    check_output({name, "_strobe_end"}, target ? get_rise(sel) : get_fall(sel), 1'b0);
    check_output({name, "_level"}, get_press(sel), target);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, %0d miscompares so far", n_err);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int hold_a;
    int hold_b;
    int rises_before;
    logic lvl_a;
    logic lvl_b;

    rst_n       = 1'b1;
    if_a.btn_raw = 1'b0;
    if_b.btn_raw = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    check_output("reset_press_a", if_a.press,      1'b0);
    check_output("reset_rise_a",  if_a.press_rise, 1'b0);
    check_output("reset_fall_a",  if_a.press_fall, 1'b0);
    check_output("reset_press_b", if_b.press,      1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    $display("[TB] reset released with button A held");
    qualify(0, 1'b1, 5, "reset_hold_rise");

    @(negedge clk);
    apply_stimulus(0, 1'b0);
    qualify(0, 1'b0, 5, "clean_fall");

    $display("[TB] bounce on A");
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      apply_stimulus(0, (i % 2) == 0);
      hold_check(0, 1'b0, 2);
    end
    @(negedge clk);
    apply_stimulus(0, 1'b1);
    qualify(0, 1'b1, 5, "bounce_then_rise");

    $display("[TB] glitch rejection on A");
    @(negedge clk);
    apply_stimulus(0, 1'b0);
    hold_check(0, 1'b1, 3);
    @(negedge clk);
    apply_stimulus(0, 1'b1);
    hold_check(0, 1'b1, 10);
    @(negedge clk);
    apply_stimulus(0, 1'b0);
    qualify(0, 1'b0, 5, "release_fall");
    @(negedge clk);
    apply_stimulus(0, 1'b1);
    hold_check(0, 1'b0, 3);
    @(negedge clk);
    apply_stimulus(0, 1'b0);
    hold_check(0, 1'b0, 10);

    $display("[TB] reset during qualification on A");
    @(negedge clk);
    apply_stimulus(0, 1'b1);
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_output("midqual_reset_press", if_a.press, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    qualify(0, 1'b1, 5, "requalify_rise");
    hold_check(0, 1'b1, 2);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_output("idle_high_reset_press", if_a.press,      1'b0);
    check_output("idle_high_reset_fall",  if_a.press_fall, 1'b0);
    @(negedge clk);
    apply_stimulus(0, 1'b0);
    rst_n = 1'b1;
    hold_check(0, 1'b0, 8);

    $display("[TB] active-high instance B with toggle consumer");
    @(negedge clk);
    apply_stimulus(1, 1'b1);
    qualify(1, 1'b1, 3, "b_rise");
    @(negedge clk);
    check_output("detect_after_first", detect, 1'b1);
    apply_stimulus(1, 1'b0);
    qualify(1, 1'b0, 3, "b_fall");
    @(negedge clk);
    apply_stimulus(1, 1'b1);
    qualify(1, 1'b1, 3, "b_rise2");
    @(negedge clk);
    apply_stimulus(1, 1'b0);
    qualify(1, 1'b0, 3, "b_fall2");
    @(negedge clk);
    check_output("detect_after_second", detect, 1'b0);
    rises_before = rise_b_n;
    for (int i = 0; i < 8; i++) begin
      apply_stimulus(1, (i % 2) == 0);
      @(negedge clk);
    end
    apply_stimulus(1, 1'b1);
    repeat (10) @(negedge clk);
    check_value("bounced_press_toggles", rise_b_n - rises_before, 1);
    check_output("detect_after_bounce", detect, 1'b1);
    apply_stimulus(1, 1'b0);
    repeat (6) @(negedge clk);

    $display("[TB] randomized phase");
    hold_a = 0;
    hold_b = 0;
    lvl_a  = 1'b0;
    lvl_b  = 1'b0;
    for (int c = 0; c < 800; c++) begin
      @(negedge clk);
      if (hold_a == 0) begin
        lvl_a  = ~lvl_a;
        hold_a = $urandom_range(1, 7);
        apply_stimulus(0, lvl_a);
      end else begin
        hold_a--;
      end
      if (hold_b == 0) begin
        lvl_b  = ~lvl_b;
        hold_b = $urandom_range(1, 4);
        apply_stimulus(1, lvl_b);
      end else begin
        hold_b--;
      end
      if ($urandom_range(0, 149) == 0) begin
        #2;
        rst_n = 1'b0;
        #1;
        check_output("rand_reset_press_a", if_a.press, 1'b0);
        check_output("rand_reset_press_b", if_b.press, 1'b0);
        rst_n = 1'b1;
      end
    end
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/botao_debounce.md
# botao_debounce

Input conditioning stage for the `botao` toggle FSM. Takes the raw mechanical push-button signal from the board pin, synchronises it into the `clk` domain and rejects contact bounce. It outputs a clean, active-high level `press` that drives `botao.press` directly, plus single-cycle rise/fall strobes for other consumers. The signal is qualified by a counter-based debounce state machine.

## Interface
- `DEBOUNCE_CYCLES`, default 50000: consecutive synchronised samples that must disagree with `press` before `press` changes (1 ms at 50 MHz). Legal range ≥ 2.
- `ACTIVE_LOW`, default 1: 1 means the pin reads 0 when pressed (board KEYs); 0 means the pin reads 1 when pressed.
- `clk` input, 1: system clock, all state on rising edge.
- `rst_n` input, 1: reset, asynchronous, active-low.
- `btn_raw` input, 1: asynchronous raw button pin.
- `press` output, 1: debounced level, 1 = pressed; feeds `botao.press`.
- `press_rise` output, 1: one-cycle strobe on a committed 0→1 of `press`.
- `press_fall` output, 1: one-cycle strobe on a committed 1→0 of `press`.

## Operation
- Polarity: `b = btn_raw ^ ACTIVE_LOW`. All internal logic sees `b` as 1 = pressed.
- Synchroniser: two flops, `sync1 <= b`, `s <= sync1`. Both reset to 0. No other logic reads `btn_raw` or `sync1`.
- Counter `cnt`: width `$clog2(DEBOUNCE_CYCLES)` (localparam). It never exceeds `DEBOUNCE_CYCLES-1`, so it never wraps.
- State machine, 4 states:
  - IDLE_LOW: `press`=0, `cnt`=0. If `s`=1, go to WAIT_HIGH with `cnt`<=1.
  - WAIT_HIGH: `press`=0.
    - If `s`=0: go to IDLE_LOW, `cnt`<=0 (bounce rejected, no strobe).
    - Else if `cnt`==`DEBOUNCE_CYCLES-1`: go to IDLE_HIGH, `cnt`<=0, `press_rise`<=1.
    - Else `cnt`<=`cnt`+1.
  - IDLE_HIGH: `press`=1, `cnt`=0. If `s`=0, go to WAIT_LOW with `cnt`<=1.
  - WAIT_LOW: mirror of WAIT_HIGH.
    - If `s`=1: go to IDLE_HIGH, `cnt`<=0.
    - Else if `cnt`==`DEBOUNCE_CYCLES-1`: go to IDLE_LOW, `cnt`<=0, `press_fall`<=1.
    - Else `cnt`<=`cnt`+1.
- Net effect: `press` changes only after exactly `DEBOUNCE_CYCLES` consecutive samples of `s` at the new value. Any single opposite sample restarts qualification from zero.
- `press`, `press_rise` and `press_fall` are registered outputs; none is combinational from `btn_raw`.
- `press_rise` and `press_fall` are never high together. Each is high for exactly one cycle, coincident with the first cycle `press` shows its new value.

## Timing
- Reset (`rst_n`=0, any time, asynchronous): `sync1`=0, `s`=0, state=IDLE_LOW, `cnt`=0, `press`=0, `press_rise`=0, `press_fall`=0.
- Reset mid-WAIT or while in IDLE_HIGH:
  - All qualification progress is discarded.
  - `press` drops to 0 immediately, with no `press_fall` strobe.
  - A button still held after `rst_n` deasserts is re-qualified from scratch.
- Latency (edge E0 is the first rising edge that captures the changed `b` into `sync1`):
  - `s` changes at E1.
  - The state machine first samples the new `s` at E2.
  - `press` and its strobe update at edge E(`DEBOUNCE_CYCLES`+1).
  - With `DEBOUNCE_CYCLES`=4: `press` changes at E5.
- Minimum stable pulse: a stable level lasting fewer than `DEBOUNCE_CYCLES` clocks (after synchronisation) never reaches `press`.
- The downstream `botao` sees at most one `press` transition per qualified level change. Its toggle period is therefore bounded below by `DEBOUNCE_CYCLES` clocks.

## Test plan
Test parameters: `DEBOUNCE_CYCLES`=4 and `ACTIVE_LOW`=1 unless stated.
- **Reset:** assert `rst_n`=0 with `btn_raw`=0 (pressed) → `press`=0, `press_rise`=0, `press_fall`=0 asynchronously. Release reset with `btn_raw` held at 0 → `press` rises 5 edges after the first capturing edge, with one `press_rise` pulse.
- **Clean press/release:** drive `btn_raw` 1→0 before E0 → `press`=1 and `press_rise`=1 at E5 only; `press_rise`=0 at E6. Then drive `btn_raw` 0→1 → `press`=0 at E5 of that event, with one `press_fall` pulse.
- **Bounce:** toggle `btn_raw` every 2 clocks for 20 clocks, then hold it pressed → no change on `press` and no strobes during the toggling. `press` rises exactly 5 edges after the final stable capture.
- **Glitch rejection:** assert pressed for exactly 3 clocks, then release → `press` stays 0 and no strobes occur. Repeat the same check from `press`=1 with a 3-clock release.
- **Reset mid-qualification:** pulse `rst_n` low while the state machine is in WAIT_HIGH with `cnt`=2 → after release, `press` requires a full 5-edge qualification again. Pulse `rst_n` low in IDLE_HIGH → `press` falls immediately with no `press_fall`.
- **Polarity and chain:** with `ACTIVE_LOW`=0 and `DEBOUNCE_CYCLES`=2, drive `btn_raw`=1 → `press` rises at E3. Connect `press` to a `botao` instance: two clean press/release cycles → `detect` goes 0→1→0, and a bounced press never causes a double toggle.
